// File: rtl/pwm_timebase.sv
// Prescaled, period-programmable PWM timebase with a wrap pulse and a ramSafe window.
// New prescale/period settings are held in one pending slot and committed only at wrap or in IDLE.
module pwm_timebase #(
    parameter int unsigned          WIDTH      = 16,
    parameter int unsigned          PRE_W      = 8,
    parameter logic [WIDTH-1:0]     SAFE_START = WIDTH'(16'hEFFF)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               cfgValid,
    output logic               cfgReady,
    input  logic [PRE_W-1:0]   cfgPrescale,
    input  logic [WIDTH-1:0]   cfgPeriod,
    output logic [WIDTH-1:0]   counter,
    output logic               ramSafe,
    output logic               wrap,
    output logic               running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [PRE_W-1:0] prescale;
        logic [WIDTH-1:0] period;
    } cfg_t;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   counter_q, counter_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    cfg_t               active_q, active_d;
    cfg_t               pend_q, pend_d;
    logic               pending_q, pending_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               ram_safe_q, ram_safe_d;
    logic               wrap_q, wrap_d;
    logic               running_q, running_d;
    logic               tick;
    logic               commit;
    logic               xfer;

    // Next-state, counting, and config commit logic
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        pre_cnt_d   = pre_cnt_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pending_d   = pending_q;
        wrap_d      = 1'b0;
        tick        = 1'b0;
        commit      = 1'b0;
        xfer        = cfgValid && cfg_ready_q;

        case (state_q)
            IDLE: begin
                counter_d = '0;
                pre_cnt_d = '0;
                commit    = pending_q;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN, DRAIN: begin
                if (pre_cnt_q == active_q.prescale) begin
                    pre_cnt_d = '0;
                    tick      = 1'b1;
                end else begin
                    pre_cnt_d = pre_cnt_q + PRE_W'(1);
                end
                if (tick) begin
                    if (counter_q == active_q.period) begin
                        counter_d = '0;
                        wrap_d    = 1'b1;
                        commit    = pending_q;
                    end else begin
                        counter_d = counter_q + WIDTH'(1);
                    end
                end
                if (state_q == RUN) begin
                    if (!enable) begin
                        state_d = DRAIN;
                    end
                end else if (enable) begin
                    state_d = RUN;
                end else if (wrap_d) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                counter_d = '0;
                pre_cnt_d = '0;
            end
        endcase

        // Commit reads the pending slot as it was before this edge's transfer
        if (commit) begin
            active_d  = pend_q;
            pending_d = 1'b0;
            pre_cnt_d = '0;
        end
        if (xfer) begin
            pend_d    = '{prescale: cfgPrescale, period: cfgPeriod};
            pending_d = 1'b1;
        end

        cfg_ready_d = !pending_d;
        running_d   = (state_d != IDLE);
        ram_safe_d  = (state_d != IDLE) && (counter_d >= SAFE_START) && !wrap_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            counter_q   <= '0;
            pre_cnt_q   <= '0;
            active_q    <= '{prescale: '0, period: '1};
            pend_q      <= '0;
            pending_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            ram_safe_q  <= 1'b0;
            wrap_q      <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            pre_cnt_q   <= pre_cnt_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pending_q   <= pending_d;
            cfg_ready_q <= cfg_ready_d;
            ram_safe_q  <= ram_safe_d;
            wrap_q      <= wrap_d;
            running_q   <= running_d;
        end
    end

    assign counter  = counter_q;
    assign ramSafe  = ram_safe_q;
    assign wrap     = wrap_q;
    assign running  = running_q;
    assign cfgReady = cfg_ready_q;

endmodule

// File: tb/tb_pwm_timebase.sv
// Directed bench for pwm_timebase: stimulus queues expected output snapshots per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_pwm_timebase;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        cfgValid;
    logic        cfgReady;
    logic [7:0]  cfgPrescale;
    logic [15:0] cfgPeriod;
    logic [15:0] counter;
    logic        ramSafe;
    logic        wrap;
    logic        running;

    pwm_timebase dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .cfgValid    (cfgValid),
        .cfgReady    (cfgReady),
        .cfgPrescale (cfgPrescale),
        .cfgPeriod   (cfgPeriod),
        .counter     (counter),
        .ramSafe     (ramSafe),
        .wrap        (wrap),
        .running     (running)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [19:0] v;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void expect_at(int at, string name, logic [15:0] cnt,
                                      logic rs, logic wr, logic run, logic rdy);
        exp_t e;
        e.at   = at;
        e.name = name;
        e.v    = {cnt, rs, wr, run, rdy};
        sb.push_back(e);
    endfunction

    // Monitor: compares every queued snapshot that is due this cycle
    always @(negedge clock) begin
        exp_t        e;
        logic [19:0] obs;
        obs = {counter, ramSafe, wrap, running, cfgReady};
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.at < cyc) begin
                errors++;
                $display("FAIL %s: snapshot for cycle %0d not observed (now %0d)", e.name, e.at, cyc);
            end else if (obs !== e.v) begin
                errors++;
                $display("FAIL %s cycle %0d: got counter=%h ramSafe=%b wrap=%b running=%b cfgReady=%b, want counter=%h ramSafe=%b wrap=%b running=%b cfgReady=%b",
                         e.name, cyc, obs[19:4], obs[3], obs[2], obs[1], obs[0],
                         e.v[19:4], e.v[3], e.v[2], e.v[1], e.v[0]);
            end
        end
    end

    task automatic goto(int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, w1, w2, w3, w4, r, s;

        reset       = 1'b1;
        enable      = 1'b0;
        cfgValid    = 1'b0;
        cfgPrescale = 8'h00;
        cfgPeriod   = 16'h0000;

        goto(2);
        expect_at(2, "reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        reset  = 1'b0;
        enable = 1'b1;
        expect_at(3, "run_start",   16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_at(4, "first_tick",  16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_at(5, "second_tick", 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1);

        // Mid-period offer is held until wrap; a second offer stalls
        c1 = 32'h1234 + 3;
        goto(c1);
        expect_at(c1, "pre_offer", 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1);
        cfgValid    = 1'b1;
        cfgPrescale = 8'h00;
        cfgPeriod   = 16'h0010;
        expect_at(c1 + 1, "ready_drop", 16'h1235, 1'b0, 1'b0, 1'b1, 1'b0);
        goto(c1 + 1);
        cfgPrescale = 8'h07;
        cfgPeriod   = 16'h0002;
        expect_at(c1 + 50, "stall", 16'h1266, 1'b0, 1'b0, 1'b1, 1'b0);
        goto(c1 + 60);
        cfgValid = 1'b0;

        expect_at(32'hEFFE + 3, "below_safe", 16'hEFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_at(32'hEFFF + 3, "safe_start", 16'hEFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_at(32'hFFFF + 3, "safe_top",   16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        w1 = 32'h10003;
        expect_at(w1,      "wrap_full",      16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_at(w1 + 1,  "new_period_1",   16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_at(w1 + 16, "new_period_top", 16'h0010, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_at(w1 + 17, "new_wrap",       16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);

        // Offer on the exact wrap edge: old period repeats once
        w2 = w1 + 34;
        goto(w2 - 1);
        cfgValid    = 1'b1;
        cfgPrescale = 8'h01;
        cfgPeriod   = 16'h0003;
        expect_at(w2, "wrap_xfer", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        goto(w2);
        cfgValid = 1'b0;
        expect_at(w2 + 16, "old_period_repeat", 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0);
        w3 = w2 + 17;
        expect_at(w3,     "deferred_commit", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_at(w3 + 1, "pre_hold",        16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_at(w3 + 2, "pre_tick",        16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_at(w3 + 7, "pre_top",         16'h0003, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_at(w3 + 8, "short_wrap",      16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);

        // Drain to IDLE, then restart and re-raise enable before wrap
        w4 = w3 + 8;
        goto(w4 + 2);
        enable = 1'b0;
        expect_at(w4 + 4,  "drain_count", 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_at(w4 + 8,  "drain_wrap",  16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_at(w4 + 12, "idle_hold",   16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        goto(w4 + 12);
        enable = 1'b1;
        r = w4 + 13;
        expect_at(r, "restart", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        goto(r + 3);
        enable = 1'b0;
        expect_at(r + 4, "drain2", 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1);
        goto(r + 5);
        enable = 1'b1;
        expect_at(r + 8,  "reenter_wrap", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_at(r + 10, "no_stop",      16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
        goto(r + 10);
        enable = 1'b0;
        expect_at(r + 16, "drain_idle", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);

        // Config offered in IDLE commits on the following cycle
        goto(r + 17);
        cfgValid    = 1'b1;
        cfgPrescale = 8'h03;
        cfgPeriod   = 16'h0009;
        expect_at(r + 18, "idle_xfer", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        goto(r + 18);
        cfgValid = 1'b0;
        expect_at(r + 19, "idle_commit", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        goto(r + 20);
        enable = 1'b1;
        s = r + 21;
        expect_at(s,      "p3_start", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_at(s + 3,  "p3_hold",  16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_at(s + 4,  "p3_tick",  16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_at(s + 39, "p3_top",   16'h0009, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_at(s + 40, "p3_wrap",  16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_at(s + 80, "p3_wrap2", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);

        // Reset with a pending config discards it and restores defaults
        goto(s + 82);
        cfgValid    = 1'b1;
        cfgPrescale = 8'h00;
        cfgPeriod   = 16'h0005;
        expect_at(s + 83, "pending_before_reset", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        goto(s + 83);
        cfgValid = 1'b0;
        goto(s + 90);
        reset = 1'b1;
        expect_at(s + 91, "mid_reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        goto(s + 91);
        reset = 1'b0;
        expect_at(s + 92, "post_reset_run", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_at(s + 98, "discarded_cfg",  16'h0006, 1'b0, 1'b0, 1'b1, 1'b1);

        goto(s + 104);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d snapshots left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
